// File: rtl/step_ctrl_pkg.sv
// Shared constants for the step controller: FSM encodings, default timing and a counter-width helper.
package step_ctrl_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] HOLD     = 2'd1;
  localparam logic [1:0] REPEAT   = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  // Defaults assume a 100 MHz system clock.
  localparam int DB_CYCLES_DEF    = 1000000;
  localparam int REPEAT_DELAY_DEF = 50000000;
  localparam int REPEAT_RATE_DEF  = 10000000;

  function automatic int cnt_width(input int span);
    return (span < 2) ? 1 : $clog2(span);
  endfunction

endpackage

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw board input.
module debounce
  import step_ctrl_pkg::*;
#(
  parameter int   DB_CYCLES = DB_CYCLES_DEF,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic db_o
);

  localparam int CW = cnt_width(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The count restarts whenever the synchronised input agrees with the debounced value.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      db_q  <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/step_ctrl.sv
// Step-button front end: debounces step/direction and issues one-cycle inc/dec pulses with auto-repeat.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic step,
  input  logic uphdnl,
  input  logic auto_en,
  output logic inc,
  output logic dec,
  output logic dir_out,
  output logic held
);

  localparam int TW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE - 1);

  logic          db_step, db_dir;
  logic          db_step_q;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pulse;
  logic          inc_q, dec_q, held_q, dir_q;

  debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b0)) u_db_step (
    .clk_i (clk),
    .rst_i (rst),
    .raw_i (step),
    .db_o  (db_step)
  );

  debounce #(.DB_CYCLES(DB_CYCLES), .RST_VAL(1'b1)) u_db_dir (
    .clk_i (clk),
    .rst_i (rst),
    .raw_i (uphdnl),
    .db_o  (db_dir)
  );

  // Release is tested first in every state, so it always beats a repeat pulse due the same cycle.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    pulse   = 1'b0;
    case (state_q)
      IDLE: begin
        if (db_step_q) begin
          pulse   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!db_step_q) begin
          state_d = IDLE;
        end else if (auto_en && timer_q == DELAY_LAST) begin
          pulse   = 1'b1;
          state_d = REPEAT;
        end else begin
          // Saturate so a held button with auto-repeat off never wraps the timer.
          timer_d = (timer_q == DELAY_LAST) ? timer_q : timer_q + TW'(1);
        end
      end
      REPEAT: begin
        if (!db_step_q) begin
          state_d = IDLE;
        end else if (!auto_en) begin
          state_d = WAIT_REL;
        end else if (timer_q == RATE_LAST) begin
          pulse = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        if (!db_step_q) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_step_q <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      held_q    <= 1'b0;
      dir_q     <= 1'b1;
    end else begin
      db_step_q <= db_step;
      state_q   <= state_d;
      timer_q   <= timer_d;
      inc_q     <= pulse & db_dir;
      dec_q     <= pulse & ~db_dir;
      held_q    <= (state_q == HOLD) || (state_q == REPEAT);
      dir_q     <= db_dir;
    end
  end

  assign inc     = inc_q;
  assign dec     = dec_q;
  assign held    = held_q;
  assign dir_out = dir_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl with short debounce/repeat timing; cycle N = posedge N sampling the stimulus.
module tb_step_ctrl;

  logic clk = 1'b0;
  logic rst, step, uphdnl, auto_en;
  logic inc, dec, dir_out, held;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  step_ctrl #(.DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .uphdnl  (uphdnl),
    .auto_en (auto_en),
    .inc     (inc),
    .dec     (dec),
    .dir_out (dir_out),
    .held    (held)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; step = 1'b0; uphdnl = 1'b1; auto_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  function automatic logic rep_pulse(input int c);
    return (c == 7) || (c >= 27 && c <= 62 && (c - 27) % 5 == 0);
  endfunction

  initial begin
    #100us;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with random inputs.
    rst = 1'b1; step = 1'b0; uphdnl = 1'b1; auto_en = 1'b0;
    #1;
    for (int i = 0; i < 10; i++) begin
      step = 1'($urandom_range(0, 1)); uphdnl = 1'($urandom_range(0, 1));
      auto_en = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("rst_inc@%0d", i), inc, 1'b0);
      check($sformatf("rst_dec@%0d", i), dec, 1'b0);
      check($sformatf("rst_held@%0d", i), held, 1'b0);
      check($sformatf("rst_dir@%0d", i), dir_out, 1'b1);
    end

    // Clean single press, direction up, no auto-repeat.
    do_reset();
    for (int c = 0; c <= 45; c++) begin
      step = (c <= 29);
      tick();
      check($sformatf("press_inc@%0d", c), inc, c == 7);
      check($sformatf("press_dec@%0d", c), dec, 1'b0);
      check($sformatf("press_held@%0d", c), held, c >= 8 && c <= 37);
      check($sformatf("press_dir@%0d", c), dir_out, 1'b1);
    end

    // Bouncing step never debounces high.
    do_reset();
    for (int c = 0; c <= 40; c++) begin
      step = (c < 20) ? ((c / 2) % 2 == 0) : 1'b0;
      tick();
      check($sformatf("bounce_inc@%0d", c), inc, 1'b0);
      check($sformatf("bounce_dec@%0d", c), dec, 1'b0);
      check($sformatf("bounce_held@%0d", c), held, 1'b0);
      check($sformatf("bounce_db@%0d", c), dut.db_step, 1'b0);
    end

    // Auto-repeat; release at 59 suppresses the pulse due at 67.
    do_reset();
    auto_en = 1'b1;
    for (int c = 0; c <= 75; c++) begin
      step = (c <= 59);
      tick();
      check($sformatf("rep_inc@%0d", c), inc, rep_pulse(c));
      check($sformatf("rep_dec@%0d", c), dec, 1'b0);
      check($sformatf("rep_held@%0d", c), held, c >= 8 && c <= 67);
    end

    // Direction down from the start: single dec pulse.
    do_reset();
    uphdnl = 1'b0;
    for (int c = 0; c <= 40; c++) begin
      step = (c <= 29);
      tick();
      check($sformatf("down_dec@%0d", c), dec, c == 7);
      check($sformatf("down_inc@%0d", c), inc, 1'b0);
      check($sformatf("down_dir@%0d", c), dir_out, c < 6);
    end

    // Flip direction at cycle 34 during repeat: pulses from 40 on are dec.
    do_reset();
    auto_en = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      step = (c <= 59);
      uphdnl = (c < 34);
      tick();
      check($sformatf("flip_inc@%0d", c), inc, rep_pulse(c) && c < 40);
      check($sformatf("flip_dec@%0d", c), dec, rep_pulse(c) && c >= 40);
    end

    // Reset asserted just after a repeat pulse with step still held.
    do_reset();
    auto_en = 1'b1;
    step = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      tick();
      if (c == 32) check("mid_pre_inc", inc, 1'b1);
    end
    rst = 1'b1;
    #1;
    check("mid_rst_inc", inc, 1'b0);
    check("mid_rst_held", held, 1'b0);
    check("mid_rst_dir", dir_out, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c <= 35; c++) begin
      tick();
      check($sformatf("mid_inc@%0d", c), inc, c == 7 || c == 27 || c == 32);
      check($sformatf("mid_held@%0d", c), held, c >= 8);
      check($sformatf("mid_dec@%0d", c), dec, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/step_ctrl.md
Name: step_ctrl

Overview:
- Front-end controller that sequences the up/down counter from raw board inputs.
- Synchronises and debounces the step button and the uphdnl direction switch.
- Issues single-cycle inc/dec enable pulses to the counter, with optional auto-repeat while step is held.
- Sits between the board pins and the counter/seven-segment datapath inside the top level.

Parameters:
- DB_CYCLES, 1000000: consecutive stable cycles required before a debounced input changes (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles from the first pulse to the first auto-repeat pulse.
- REPEAT_RATE, 10000000: cycles between successive auto-repeat pulses.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- step  in  1  raw step pushbutton, asynchronous, bouncy.
- uphdnl  in  1  raw direction switch; 1 = up, 0 = down.
- auto_en  in  1  synchronous level; 1 enables auto-repeat while step is held.
- inc  out  1  one-cycle count-up enable.
- dec  out  1  one-cycle count-down enable.
- dir_out  out  1  current debounced direction, for display/LED.
- held  out  1  high while the FSM is in HOLD or REPEAT.

Behaviour:
- Reset values: inc=0, dec=0, held=0, dir_out=1, db_step=0, db_dir=1, all timers 0, FSM=IDLE.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Synchronisers: each raw input passes through a 2-flop synchroniser.
- Debounce, per input:
  - Stable counter increments while sync != db.
  - The counter clears on any cycle where sync == db.
  - db takes sync on the cycle the counter would reach DB_CYCLES; the counter then clears.
- Pulse latency: the first inc/dec pulse is high exactly DB_CYCLES+3 clocks after the first rising clk edge that samples step=1, given step is clean.
- FSM states: IDLE, HOLD, REPEAT, WAIT_REL.
  - IDLE: db_step 0->1 emits one pulse, then goes to HOLD and clears the timer.
  - HOLD: db_step=0 goes to IDLE.
    - Otherwise, if auto_en=1 and the timer reaches REPEAT_DELAY-1: emit pulse, go to REPEAT, clear the timer.
    - If auto_en=0: stay in HOLD with no pulses.
  - REPEAT: db_step=0 goes to IDLE.
    - Else auto_en=0 goes to WAIT_REL.
    - Else, when the timer reaches REPEAT_RATE-1: emit pulse and clear the timer.
  - WAIT_REL: no pulses; db_step=0 goes to IDLE.
- Priority: release beats a repeat pulse due in the same cycle; no pulse is emitted.
- Pulse steering: each pulse asserts inc if db_dir=1, otherwise dec. inc and dec are never high together; each pulse lasts exactly one cycle.
- Direction changes:
  - A direction change takes effect on the first pulse after db_dir updates.
  - A mid-repeat change switches subsequent pulses without restarting the repeat timer.
- dir_out = db_dir, registered.
- Timer width: clog2 of max(REPEAT_DELAY, REPEAT_RATE) bits. Debounce counter width: clog2(DB_CYCLES+1) bits. No wrap: timers clear on reaching their terminal value.
- Reset mid-operation: all state returns to reset values immediately, and any in-flight pulse is suppressed. If step is still held after reset deasserts, it is treated as a new press: one pulse after DB_CYCLES+3 clocks.

Decomposition:
- Shared include/package step_ctrl_pkg:
  - FSM state localparams (IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2, WAIT_REL=2'd3).
  - Default timing constants.
- One sub-module, debounce:
  - Contents: synchroniser, stable counter and debounced register.
  - Parameters: DB_CYCLES, RST_VAL.
  - Instantiated twice: step with RST_VAL=0, uphdnl with RST_VAL=1.

Test Plan:
- All cases run with DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5. Cycle 0 is the first edge sampling the stimulus.
- Reset: rst=1 for 10 cycles with random inputs -> inc=dec=held=0, dir_out=1 throughout.
- Clean single press: uphdnl=1, auto_en=0, step high cycles 0-29 -> exactly one inc pulse at cycle 7; dec never asserts; held high from cycle 8 until release is debounced.
- Bounce rejection: step toggles every 2 cycles for 20 cycles, then stays low -> no inc/dec pulse; db_step never rises.
- Auto-repeat: auto_en=1, uphdnl=1, step high cycles 0-59 -> 9 inc pulses, at cycles 7, 27, 32, 37, 42, 47, 52, 57, 62; no pulse at 67, when release is seen.
- Direction:
  - uphdnl=0 stable, single press -> one dec pulse at cycle 7, dir_out=0.
  - During auto-repeat, flip uphdnl 1->0 -> pulses switch from inc to dec starting with the first pulse at or after flip+DB_CYCLES+2.
- Reset mid-repeat: rst pulsed during REPEAT with step held -> outputs clear immediately. After rst deasserts, exactly one inc pulse occurs DB_CYCLES+3 clocks later, then repeat resumes only after REPEAT_DELAY.
